// File: rtl/l0_zero_fifo_pkg.sv
// ---------------------------------------------------------------------------
// l0_zero_fifo_pkg
// Shared constants and types for the L0 input buffer. The zero detector and
// the array top use the same defaults, so they are kept here.
//   L0_BW    : data bits per lane
//   L0_ROW   : lanes per row
//   L0_DEPTH : entries per lane FIFO (power of two, >= 2)
//   L0_LW    : tagged lane width (data plus zero flag)
//   L0_PTR_W : pointer width (one wrap bit above the address)
// ---------------------------------------------------------------------------
package l0_zero_fifo_pkg;

  localparam int L0_BW    = 4;
  localparam int L0_ROW   = 8;
  localparam int L0_DEPTH = 64;
  localparam int L0_LW    = L0_BW + 1;
  localparam int L0_PTR_W = $clog2(L0_DEPTH) + 1;

  // One tagged lane. The zero flag sits in the MSB.
  typedef struct packed {
    logic              zero_flag;
    logic [L0_BW-1:0]  data;
  } l0_lane_t;

endpackage

// File: rtl/l0_lane_fifo.sv
// ---------------------------------------------------------------------------
// l0_lane_fifo
// Single-lane FIFO used once per row lane inside l0_zero_fifo.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (pointers only, contents discarded)
//   wr    : push din (ignored when full)
//   rd    : pop head (ignored when empty)
//   din   : write data
//   dout  : head entry, combinational; valid whenever empty is low
//   full  : FIFO holds DEPTH entries
//   empty : FIFO holds no entries
// Pointers carry one extra wrap bit, so full and empty are told apart
// without a separate counter.
// ---------------------------------------------------------------------------
module l0_lane_fifo
  import l0_zero_fifo_pkg::*;
#(
  parameter int LW    = L0_LW,
  parameter int DEPTH = L0_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [LW-1:0] din,
  output logic [LW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [LW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic             push_s;
  logic             pop_s;

  // Status flags, pointer next-state and head read, all from pre-edge pointers.
  always_comb begin
    full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
             (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty  = (wr_ptr_q == rd_ptr_q);
    push_s = wr && !full;
    pop_s  = rd && !empty;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    dout = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate access.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/l0_zero_fifo.sv
// ---------------------------------------------------------------------------
// l0_zero_fifo
// Per-row L0 input buffer sitting behind the zero-detector row. Each cycle it
// can accept one zero-tagged vector (all lanes together) and it drains the
// lanes with a one-cycle-per-lane stagger, giving the skewed west-edge feed
// of the systolic array. The zero flag is carried bit-exact.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   in       : tagged vector, lane i at [(i+1)*LW-1 : i*LW], MSB = zero flag
//   wr       : write strobe, all lanes written together
//   rd       : launches one staggered pop wave (lane i pops i cycles later)
//   out      : registered lane outputs, same packing as in
//   o_valid  : per-lane strobe, high the cycle after that lane popped
//   o_full   : some lane FIFO is full
//   o_ready  : !o_full
//   o_empty  : every lane FIFO is empty
//   zero_cnt : (only with L0_ZERO_STATS_EN) saturating count of popped
//              entries whose zero flag is set
// Optional build macro: L0_ZERO_STATS_EN.
// ---------------------------------------------------------------------------
module l0_zero_fifo
  import l0_zero_fifo_pkg::*;
#(
  parameter int bw    = L0_BW,
  parameter int row   = L0_ROW,
  parameter int depth = L0_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [row*(bw+1)-1:0] in,
  input  logic                  wr,
  input  logic                  rd,
  output logic [row*(bw+1)-1:0] out,
  output logic [row-1:0]        o_valid,
  output logic                  o_full,
  output logic                  o_ready,
  output logic                  o_empty
`ifdef L0_ZERO_STATS_EN
  ,
  output logic [15:0]           zero_cnt
`endif
);

  localparam int LW = bw + 1;
  localparam int VW = row * LW;

  logic [row-2:0] stag_q;
  logic [row-2:0] stag_d;
  logic [row-1:0] rd_en_s;
  logic [row-1:0] pop_s;
  logic [row-1:0] full_s;
  logic [row-1:0] empty_s;
  logic [VW-1:0]  dout_s;
  logic           wr_all_s;
  logic [VW-1:0]  out_q;
  logic [VW-1:0]  out_d;
  logic [row-1:0] o_valid_q;
  logic [row-1:0] o_valid_d;

  // One independent FIFO per lane; they share the write strobe.
  for (genvar g = 0; g < row; g++) begin : g_lane
    l0_lane_fifo #(
      .LW    (LW),
      .DEPTH (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_all_s),
      .rd    (pop_s[g]),
      .din   (in[g*LW +: LW]),
      .dout  (dout_s[g*LW +: LW]),
      .full  (full_s[g]),
      .empty (empty_s[g])
    );
  end

  // Stagger wave, pop decisions, write gating and output next-state.
  always_comb begin
    // rd_en[0] is rd itself; rd_en[i] is rd delayed i cycles.
    rd_en_s  = {stag_q, rd};
    stag_d   = rd_en_s[row-2:0];
    // Lanes drain at different times, so full is the OR over all lanes.
    wr_all_s = wr && !(|full_s);
    // A reset cycle aborts the wave: nothing pops.
    if (reset) begin
      pop_s = {row{1'b0}};
    end else begin
      pop_s = rd_en_s & ~empty_s;
    end
    out_d     = out_q;
    o_valid_d = pop_s;
    for (int i = 0; i < row; i++) begin
      if (pop_s[i]) begin
        out_d[i*LW +: LW] = dout_s[i*LW +: LW];
      end else begin
        out_d[i*LW +: LW] = out_q[i*LW +: LW];
      end
    end
  end

  // Stagger shift register and registered lane outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stag_q    <= {(row-1){1'b0}};
      out_q     <= {VW{1'b0}};
      o_valid_q <= {row{1'b0}};
    end else begin
      stag_q    <= stag_d;
      out_q     <= out_d;
      o_valid_q <= o_valid_d;
    end
  end

  // Status is combinational from the lane pointers.
  always_comb begin
    out     = out_q;
    o_valid = o_valid_q;
    o_full  = |full_s;
    o_ready = !(|full_s);
    o_empty = &empty_s;
  end

`ifdef L0_ZERO_STATS_EN
  logic [15:0] zero_cnt_q;
  logic [15:0] zero_cnt_d;
  logic [16:0] zero_sum_s;

  // Add the number of flagged pops this cycle, saturating at all-ones.
  always_comb begin
    zero_sum_s = {1'b0, zero_cnt_q};
    for (int i = 0; i < row; i++) begin
      if (pop_s[i] && dout_s[i*LW + LW - 1]) begin
        zero_sum_s = zero_sum_s + 17'd1;
      end else begin
        zero_sum_s = zero_sum_s;
      end
    end
    if (zero_sum_s[16]) begin
      zero_cnt_d = 16'hFFFF;
    end else begin
      zero_cnt_d = zero_sum_s[15:0];
    end
  end

  // Statistics counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt_q <= 16'd0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_l0_zero_fifo.sv
// Self-checking bench for l0_zero_fifo (row=8, bw=4, depth=64).
// Reference model: one queue per lane plus a history of rd requests; lane i
// pops in a cycle when rd was asserted i cycles earlier and its queue is
// non-empty. Full/empty decisions use the state before the edge.
module tb_l0_zero_fifo;
  import l0_zero_fifo_pkg::*;

  localparam int BW    = 4;
  localparam int ROW   = 8;
  localparam int DEPTH = 64;
  localparam int LW    = BW + 1;
  localparam int VW    = ROW * LW;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           wr    = 1'b0;
  logic           rd    = 1'b0;
  logic [VW-1:0]  in_v  = '0;
  logic [VW-1:0]  out;
  logic [ROW-1:0] o_valid;
  logic           o_full;
  logic           o_ready;
  logic           o_empty;
`ifdef L0_ZERO_STATS_EN
  logic [15:0]    zero_cnt;
`endif

  l0_zero_fifo #(.bw(BW), .row(ROW), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_v),
    .wr      (wr),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_empty (o_empty)
`ifdef L0_ZERO_STATS_EN
    ,
    .zero_cnt(zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [LW-1:0]  mq [ROW][$];
  logic [ROW-1:0] hist = '0;      // hist[k]: rd was high k+1 cycles ago
  logic [VW-1:0]  exp_out = '0;
  logic [ROW-1:0] exp_valid = '0;
  int             exp_zc = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Vector whose lane i holds (base+i) mod 32.
  function automatic logic [VW-1:0] ramp(input int base);
    logic [VW-1:0] v;
    for (int i = 0; i < ROW; i++) v[i*LW +: LW] = 5'((base + i) % 32);
    return v;
  endfunction

  // One clock: drive, advance the model, then compare after the edge.
  task automatic cycle(input logic w, input logic [VW-1:0] v, input logic r, input logic rst);
    logic          pre_full;
    logic [VW-1:0] nout;
    logic [ROW-1:0] nval;
    logic          rd_now;
    logic          exp_full;
    logic          exp_empty;
    int            zadd;
    wr = w; in_v = v; rd = r; reset = rst;
    pre_full = 1'b0;
    for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) pre_full = 1'b1;
    nout = exp_out;
    nval = '0;
    zadd = 0;
    if (rst) begin
      for (int i = 0; i < ROW; i++) mq[i].delete();
      nout = '0;
      hist = '0;
      exp_zc = 0;
    end else begin
      for (int i = 0; i < ROW; i++) begin
        rd_now = (i == 0) ? r : hist[i-1];
        if (rd_now && mq[i].size() > 0) begin
          nout[i*LW +: LW] = mq[i].pop_front();
          nval[i] = 1'b1;
          if (nout[i*LW + LW - 1]) zadd++;
        end
      end
      if (w && !pre_full)
        for (int i = 0; i < ROW; i++) mq[i].push_back(v[i*LW +: LW]);
      hist = {hist[ROW-2:0], r};
      exp_zc = (exp_zc + zadd > 65535) ? 65535 : exp_zc + zadd;
    end
    exp_out = nout;
    exp_valid = nval;
    @(posedge clk);
    #1;
    exp_full = 1'b0;
    exp_empty = 1'b1;
    for (int i = 0; i < ROW; i++) begin
      if (mq[i].size() == DEPTH) exp_full = 1'b1;
      if (mq[i].size() != 0) exp_empty = 1'b0;
    end
    check_eq("out", 64'(out), 64'(exp_out));
    check_eq("o_valid", 64'(o_valid), 64'(exp_valid));
    check_eq("o_full", 64'(o_full), 64'(exp_full));
    check_eq("o_ready", 64'(o_ready), 64'(!exp_full));
    check_eq("o_empty", 64'(o_empty), 64'(exp_empty));
`ifdef L0_ZERO_STATS_EN
    check_eq("zero_cnt", 64'(zero_cnt), 64'(exp_zc));
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [VW-1:0] zv;
    logic [63:0]   rnd;
    // Reset state
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // 1. Staggered read: lane i = i+1, three vectors, single rd.
    for (int k = 0; k < 3; k++) cycle(1'b1, ramp(1), 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(ROW + 2);

    // 2. Zero tagging.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < ROW; i++) zv[i*LW +: LW] = (i < 4) ? 5'b10000 : 5'b00111;
    cycle(1'b1, zv, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(ROW + 1);
    check_eq("zero_tag_out", 64'(out), 64'(zv));

    // 3. Full boundary: 65 writes, 65 reads.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 1; k++) cycle(1'b1, ramp(k), 1'b0, 1'b0);
    check_eq("full_flag", 64'(o_full), 64'(1));
    for (int k = 0; k < DEPTH + 1; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle(ROW + 1);
    check_eq("drained_empty", 64'(o_empty), 64'(1));

    // 4. Read on empty, then normal traffic.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle(ROW);
    cycle(1'b1, ramp(17), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(ROW + 1);

    // 5. Reset mid-wave.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, ramp(3 * k), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(ROW + 1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rnd = {$urandom(), $urandom()};
      cycle(($urandom_range(0, 2) != 0), rnd[VW-1:0], ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 149) == 0));
    end
    idle(ROW + 1);

`ifdef L0_ZERO_STATS_EN
    // 6. Stats: 10 vectors with 3 flagged lanes each, then saturation.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < ROW; i++) zv[i*LW +: LW] = (i < 3) ? 5'b10101 : 5'b00101;
    for (int k = 0; k < 10; k++) cycle(1'b1, zv, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle(ROW + 1);
    check_eq("zero_cnt_30", 64'(zero_cnt), 64'(30));
    for (int i = 0; i < ROW; i++) zv[i*LW +: LW] = 5'b10000;
    for (int r = 0; r < 130; r++) begin
      for (int k = 0; k < DEPTH; k++) cycle(1'b1, zv, 1'b0, 1'b0);
      for (int k = 0; k < DEPTH; k++) cycle(1'b0, '0, 1'b1, 1'b0);
      idle(ROW);
    end
    check_eq("zero_cnt_sat", 64'(zero_cnt), 64'(16'hFFFF));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
